// File: rtl/im_boot_loader.sv
// Boot loader: length-prefixed byte stream to instruction memory; holds core in reset.
// Optional trailing XOR checksum byte enabled by IM_LOADER_CHECKSUM_EN.
module im_boot_loader #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
`ifdef IM_LOADER_CHECKSUM_EN
    CSUM,
    HALT,
`endif
    DONE
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state;
  logic [1:0]  lane;
  logic [15:0] wcnt;
  logic [15:0] nwords;
  logic [23:0] shreg;
  logic        acc;
  logic        last_word;
  logic [15:0] n_len;
  logic [31:0] word;
`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  always_comb begin
    rx_ready = (state == LEN_HI) || (state == LEN_LO) ||
               (state == DATA);
`ifdef IM_LOADER_CHECKSUM_EN
    if (state == CSUM) rx_ready = 1'b1;
`endif
  end

  assign acc       = rx_valid && rx_ready;
  assign n_len     = {nwords[15:8], rx_data};
  assign word      = {shreg, rx_data};
  assign last_word = (wcnt == nwords - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LEN_HI;
      lane     <= 2'd0;
      wcnt     <= 16'd0;
      nwords   <= 16'd0;
      shreg    <= 24'd0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= 32'd0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef IM_LOADER_CHECKSUM_EN
      csum     <= 8'd0;
`endif
    end else begin
      im_we <= 1'b0;
      if (reload) begin
        // a byte accepted in the same cycle is dropped
        state   <= LEN_HI;
        lane    <= 2'd0;
        wcnt    <= 16'd0;
        err     <= 1'b0;
        cpu_rst <= 1'b1;
        done    <= 1'b0;
      end else begin
        case (state)
          LEN_HI: begin
            if (acc) begin
              nwords[15:8] <= rx_data;
              state        <= LEN_LO;
            end
          end
          LEN_LO: begin
            if (acc) begin
              nwords <= n_len;
              wcnt   <= 16'd0;
              lane   <= 2'd0;
`ifdef IM_LOADER_CHECKSUM_EN
              csum   <= 8'd0;
`endif
              if ({1'b0, n_len} > DEPTH_L) err <= 1'b1;
              if (n_len != 16'd0) state <= DATA;
`ifdef IM_LOADER_CHECKSUM_EN
              else state <= CSUM;
`else
              else state <= DONE;
`endif
            end
          end
          DATA: begin
            if (acc) begin
              lane  <= lane + 2'd1;
              shreg <= word[23:0];
`ifdef IM_LOADER_CHECKSUM_EN
              csum  <= csum ^ rx_data;
`endif
              if (lane == 2'd3) begin
                // words beyond memory depth are consumed silently
                if ({1'b0, wcnt} < DEPTH_L) begin
                  im_we    <= 1'b1;
                  im_addr  <= wcnt[ADDR_W-1:0];
                  im_wdata <= word;
                end
                wcnt <= wcnt + 16'd1;
`ifdef IM_LOADER_CHECKSUM_EN
                if (last_word) state <= CSUM;
`else
                if (last_word) state <= DONE;
`endif
              end
            end
          end
`ifdef IM_LOADER_CHECKSUM_EN
          CSUM: begin
            if (acc) begin
              if (rx_data == csum) begin
                state <= DONE;
              end else begin
                state <= HALT;
                err   <= 1'b1;
              end
            end
          end
          HALT: begin
            cpu_rst <= 1'b1;
            done    <= 1'b0;
          end
`endif
          DONE: begin
            done    <= 1'b1;
            cpu_rst <= 1'b0;
          end
          default: state <= LEN_HI;
        endcase
      end
    end
  end

endmodule
